// File: rtl/reorder_buffer_mc.sv
// Multi-port reorder buffer: in-order allocate, CDB_N-port out-of-order completion,
// up to COMMIT_N in-order retirements per cycle, registered flush on a retired mispredict.
module reorder_buffer_mc #(
  parameter  int DEPTH    = 32,
  parameter  int XLEN     = 32,
  parameter  int CDB_N    = 2,
  parameter  int COMMIT_N = 2,
  localparam int TAG_W    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alloc_valid,
  output logic                    alloc_ready,
  input  logic [4:0]              alloc_rd,
  input  logic [XLEN-1:0]         alloc_pc,
  input  logic [2:0]              alloc_type,
  output logic [TAG_W-1:0]        alloc_tag,
  input  logic [CDB_N-1:0]        cdb_valid,
  input  logic [CDB_N*TAG_W-1:0]  cdb_tag,
  input  logic [CDB_N*XLEN-1:0]   cdb_value,
  input  logic [CDB_N-1:0]        cdb_mispredict,
  input  logic [CDB_N*XLEN-1:0]   cdb_target,
  output logic [COMMIT_N-1:0]     commit_valid,
  output logic [COMMIT_N*5-1:0]   commit_rd,
  output logic [COMMIT_N*XLEN-1:0] commit_value,
  output logic [COMMIT_N*3-1:0]   commit_type,
  output logic                    flush,
  output logic [XLEN-1:0]         flush_pc,
  output logic [TAG_W-1:0]        rob_head,
  output logic [TAG_W-1:0]        rob_tail,
  output logic [TAG_W:0]          count,
  output logic                    empty,
  output logic                    full
);

  logic [DEPTH-1:0]   busy_q;
  logic [DEPTH-1:0]   done_q;
  logic [DEPTH-1:0]   misp_q;
  logic [4:0]         rd_q     [DEPTH];
  logic [XLEN-1:0]    pc_q     [DEPTH];
  logic [2:0]         type_q   [DEPTH];
  logic [XLEN-1:0]    value_q  [DEPTH];
  logic [XLEN-1:0]    target_q [DEPTH];

  logic [TAG_W-1:0]   head_q, head_d;
  logic [TAG_W-1:0]   tail_q, tail_d;
  logic [TAG_W:0]     count_q, count_d;
  logic               flush_q;
  logic [XLEN-1:0]    flush_pc_q;

  logic               alloc_fire;
  logic [TAG_W:0]     n_commit;
  logic               misp_commit;
  logic [XLEN-1:0]    misp_target;
  logic               chain;
  logic [TAG_W-1:0]   slot_idx;

  logic [TAG_W-1:0]   cdb_tag_a    [CDB_N];
  logic [XLEN-1:0]    cdb_value_a  [CDB_N];
  logic [XLEN-1:0]    cdb_target_a [CDB_N];

  logic [XLEN-1:0]    unused_pc_fold;

  assign full        = (count_q == (TAG_W+1)'(DEPTH));
  assign empty       = (count_q == '0);
  assign alloc_ready = !full && !flush_q;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_tag   = tail_q;
  assign rob_head    = head_q;
  assign rob_tail    = tail_q;
  assign count       = count_q;
  assign flush       = flush_q;
  assign flush_pc    = flush_pc_q;

  always_comb begin
    for (int p = 0; p < CDB_N; p++) begin
      cdb_tag_a[p]    = cdb_tag[p*TAG_W +: TAG_W];
      cdb_value_a[p]  = cdb_value[p*XLEN +: XLEN];
      cdb_target_a[p] = cdb_target[p*XLEN +: XLEN];
    end
  end

  // Retirement window: a slot retires only if every older slot retires and
  // no older slot carried a mispredict.
  always_comb begin
    commit_valid = '0;
    commit_rd    = '0;
    commit_value = '0;
    commit_type  = '0;
    n_commit     = '0;
    misp_commit  = 1'b0;
    misp_target  = '0;
    chain        = 1'b1;
    slot_idx     = head_q;
    for (int i = 0; i < COMMIT_N; i++) begin
      slot_idx = head_q + TAG_W'(i);
      chain    = chain && busy_q[slot_idx] && done_q[slot_idx] && !misp_commit;
      if (chain) begin
        commit_valid[i]            = 1'b1;
        commit_rd[i*5 +: 5]        = rd_q[slot_idx];
        commit_value[i*XLEN +: XLEN] = value_q[slot_idx];
        commit_type[i*3 +: 3]      = type_q[slot_idx];
        n_commit                   = n_commit + (TAG_W+1)'(1);
        if (misp_q[slot_idx]) begin
          misp_commit = 1'b1;
          misp_target = target_q[slot_idx];
        end
      end
    end
  end

  always_comb begin
    head_d = head_q + n_commit[TAG_W-1:0];
    if (misp_commit) begin
      tail_d  = head_d;
      count_d = '0;
    end else begin
      tail_d  = tail_q + {{(TAG_W-1){1'b0}}, alloc_fire};
      count_d = count_q + {{TAG_W{1'b0}}, alloc_fire} - n_commit;
    end
  end

  // PC is held per entry for debug visibility; retirement never reads it.
  always_comb begin
    unused_pc_fold = '0;
    for (int e = 0; e < DEPTH; e++) unused_pc_fold = unused_pc_fold ^ pc_q[e];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      done_q     <= '0;
      misp_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        rd_q[e]     <= '0;
        pc_q[e]     <= '0;
        type_q[e]   <= '0;
        value_q[e]  <= '0;
        target_q[e] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      flush_q <= misp_commit;
      if (misp_commit) flush_pc_q <= misp_target;

      if (misp_commit) begin
        busy_q <= '0;
      end else begin
        for (int i = 0; i < COMMIT_N; i++) begin
          if (commit_valid[i]) busy_q[head_q + TAG_W'(i)] <= 1'b0;
        end
        if (alloc_fire) begin
          busy_q[tail_q] <= 1'b1;
          done_q[tail_q] <= 1'b0;
          misp_q[tail_q] <= 1'b0;
          rd_q[tail_q]   <= alloc_rd;
          pc_q[tail_q]   <= alloc_pc;
          type_q[tail_q] <= alloc_type;
        end
        // Highest port first so the lowest port's write lands last and wins.
        for (int p = CDB_N-1; p >= 0; p--) begin
          if (cdb_valid[p] && busy_q[cdb_tag_a[p]] && !done_q[cdb_tag_a[p]]) begin
            done_q[cdb_tag_a[p]]   <= 1'b1;
            misp_q[cdb_tag_a[p]]   <= cdb_mispredict[p];
            value_q[cdb_tag_a[p]]  <= cdb_value_a[p];
            target_q[cdb_tag_a[p]] <= cdb_target_a[p];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Scoreboard bench for reorder_buffer_mc: directed stimulus pushes expected
// retirements/flushes; a negedge monitor pops and compares them.
module tb_reorder_buffer_mc;
  localparam int DEPTH = 32, XLEN = 32, CDB_N = 2, COMMIT_N = 2, TAG_W = 5;

  logic                     clk, rst_n;
  logic                     alloc_valid, alloc_ready;
  logic [4:0]               alloc_rd;
  logic [XLEN-1:0]          alloc_pc;
  logic [2:0]               alloc_type;
  logic [TAG_W-1:0]         alloc_tag;
  logic [CDB_N-1:0]         cdb_valid, cdb_mispredict;
  logic [CDB_N*TAG_W-1:0]   cdb_tag;
  logic [CDB_N*XLEN-1:0]    cdb_value, cdb_target;
  logic [COMMIT_N-1:0]      commit_valid;
  logic [COMMIT_N*5-1:0]    commit_rd;
  logic [COMMIT_N*XLEN-1:0] commit_value;
  logic [COMMIT_N*3-1:0]    commit_type;
  logic                     flush;
  logic [XLEN-1:0]          flush_pc;
  logic [TAG_W-1:0]         rob_head, rob_tail;
  logic [TAG_W:0]           count;
  logic                     empty, full;

  reorder_buffer_mc #(.DEPTH(DEPTH), .XLEN(XLEN), .CDB_N(CDB_N), .COMMIT_N(COMMIT_N)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rd(alloc_rd),
    .alloc_pc(alloc_pc), .alloc_type(alloc_type), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_type(commit_type), .flush(flush), .flush_pc(flush_pc),
    .rob_head(rob_head), .rob_tail(rob_tail), .count(count), .empty(empty), .full(full)
  );

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] value;
    logic [2:0]      typ;
  } commit_t;

  commit_t         exp_commit_q[$];
  logic [XLEN-1:0] exp_flush_q[$];
  int n_pass  = 0;
  int n_total = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every presented retirement and flush is matched against the scoreboard.
  always @(negedge clk) begin
    commit_t e;
    if (rst_n) begin
      for (int s = 0; s < COMMIT_N; s++) begin
        if (commit_valid[s]) begin
          if (exp_commit_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_commit slot%0d: got rd=%0d value=0x%0h expected none",
                     s, commit_rd[s*5 +: 5], commit_value[s*XLEN +: XLEN]);
          end else begin
            e = exp_commit_q.pop_front();
            chk("commit_rd",    commit_rd[s*5 +: 5],         e.rd);
            chk("commit_value", commit_value[s*XLEN +: XLEN], e.value);
            chk("commit_type",  commit_type[s*3 +: 3],       e.typ);
          end
        end
      end
      if (flush) begin
        if (exp_flush_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_flush: got flush_pc=0x%0h expected no flush", flush_pc);
        end else begin
          chk("flush_pc", flush_pc, exp_flush_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    alloc_valid    = 1'b0;
    cdb_valid      = '0;
    cdb_tag        = '0;
    cdb_value      = '0;
    cdb_mispredict = '0;
    cdb_target     = '0;
  endtask

  task automatic push_c(input int rd, input logic [XLEN-1:0] val, input int typ);
    commit_t e;
    e.rd = 5'(rd);
    e.value = val;
    e.typ = 3'(typ);
    exp_commit_q.push_back(e);
  endtask

  task automatic do_alloc(input int rd, input int typ, input int exp_tag);
    alloc_valid = 1'b1;
    alloc_rd    = 5'(rd);
    alloc_type  = 3'(typ);
    alloc_pc    = 32'h1000 + 32'(exp_tag * 4);
    chk("alloc_tag", alloc_tag, exp_tag);
    chk("alloc_ready", alloc_ready, 1);
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic cdb(input int p, input int tag, input logic [XLEN-1:0] val,
                     input logic m, input logic [XLEN-1:0] tgt);
    cdb_valid[p]                 = 1'b1;
    cdb_tag[p*TAG_W +: TAG_W]    = 5'(tag);
    cdb_value[p*XLEN +: XLEN]    = val;
    cdb_mispredict[p]            = m;
    cdb_target[p*XLEN +: XLEN]   = tgt;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_head", rob_head, 0);
    chk("rst_tail", rob_tail, 0);
    chk("rst_flush", flush, 0);
    chk("rst_commit_valid", commit_valid, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_count", count, 0);
    chk("post_rst_alloc_ready", alloc_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    alloc_rd = '0; alloc_pc = '0; alloc_type = '0;
    rst_n = 1'b0;
    tick();
    chk("rst_commit_rd", commit_rd, 0);
    chk("rst_commit_value", commit_value, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("reset_count", count, 0);
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_alloc_ready", alloc_ready, 1);
    chk("reset_flush", flush, 0);
    chk("reset_flush_pc", flush_pc, 0);
    chk("reset_head", rob_head, 0);
    chk("reset_tail", rob_tail, 0);
    chk("reset_commit_valid", commit_valid, 0);

    // In-order dual commit
    do_alloc(1, 1, 0);
    do_alloc(2, 2, 1);
    do_alloc(3, 3, 2);
    chk("t1_count", count, 3);
    cdb(0, 2, 32'hC, 1'b0, 32'h0);
    tick(); clr();
    chk("t1_no_commit_yet", commit_valid, 2'b00);
    push_c(1, 32'hA, 1); push_c(2, 32'hB, 2); push_c(3, 32'hC, 3);
    cdb(0, 0, 32'hA, 1'b0, 32'h0);
    cdb(1, 1, 32'hB, 1'b0, 32'h0);
    tick(); clr();
    chk("t1_dual_commit", commit_valid, 2'b11);
    tick();
    chk("t1_single_commit", commit_valid, 2'b01);
    tick();
    chk("t1_count_after", count, 0);
    chk("t1_head_after", rob_head, 3);
    chk("t1_tail_after", rob_tail, 3);

    // CDB conflict, late write to a done entry, rd=0 retirement
    do_alloc(0, 5, 3);
    do_alloc(5, 6, 4);
    cdb(0, 4, 32'h11, 1'b0, 32'h0);
    cdb(1, 4, 32'h22, 1'b0, 32'h0);
    tick(); clr();
    chk("t2_no_commit_yet", commit_valid, 2'b00);
    push_c(0, 32'h33, 5); push_c(5, 32'h11, 6);
    cdb(0, 3, 32'h33, 1'b0, 32'h0);
    cdb(1, 4, 32'h99, 1'b0, 32'h0);
    tick(); clr();
    chk("t2_dual_commit", commit_valid, 2'b11);
    tick();
    chk("t2_count_after", count, 0);
    chk("t2_head_after", rob_head, 5);

    // Reset mid-run with 5 busy entries
    for (int k = 0; k < 5; k++) do_alloc(7 + k, 0, 5 + k);
    chk("t3_count_busy", count, 5);
    do_reset();

    // Full and wrap
    for (int k = 0; k < DEPTH; k++) do_alloc((k % 31) + 1, k % 8, k);
    chk("t4_full", full, 1);
    chk("t4_alloc_ready", alloc_ready, 0);
    chk("t4_count", count, 32);
    alloc_valid = 1'b1; alloc_rd = 5'd9;
    tick(); alloc_valid = 1'b0;
    chk("t4_count_blocked", count, 32);
    chk("t4_tail_blocked", rob_tail, 0);
    push_c(1, 32'h100, 0); push_c(2, 32'h101, 1);
    cdb(0, 0, 32'h100, 1'b0, 32'h0);
    cdb(1, 1, 32'h101, 1'b0, 32'h0);
    tick(); clr();
    chk("t4_commit_pair", commit_valid, 2'b11);
    chk("t4_count_commit_cycle", count, 32);
    alloc_valid = 1'b1; alloc_rd = 5'd20;
    tick(); alloc_valid = 1'b0;
    chk("t4_no_bypass_count", count, 30);
    chk("t4_head", rob_head, 2);
    chk("t4_tail", rob_tail, 0);
    chk("t4_not_full", full, 0);
    do_alloc(20, 4, 0);
    do_alloc(21, 5, 1);
    chk("t4_refill_count", count, 32);
    chk("t4_refill_tail", rob_tail, 2);
    chk("t4_refill_full", full, 1);

    // Mispredict with a full buffer: younger slot blocked, everything squashed
    push_c(3, 32'h222, 2);
    exp_flush_q.push_back(32'h3000);
    cdb(0, 2, 32'h222, 1'b1, 32'h3000);
    cdb(1, 3, 32'h333, 1'b0, 32'h0);
    tick(); clr();
    chk("t5_misp_blocks_slot1", commit_valid, 2'b01);
    tick();
    chk("t5_flush", flush, 1);
    chk("t5_flush_pc", flush_pc, 32'h3000);
    chk("t5_count", count, 0);
    chk("t5_head", rob_head, 3);
    chk("t5_tail", rob_tail, 3);
    chk("t5_alloc_ready", alloc_ready, 0);
    tick();
    chk("t5_flush_drop", flush, 0);
    chk("t5_alloc_ready_back", alloc_ready, 1);
    do_reset();

    // Mispredict on tag 1 with allocation attempted in the commit cycle
    do_alloc(10, 1, 0);
    do_alloc(11, 2, 1);
    do_alloc(12, 3, 2);
    do_alloc(13, 4, 3);
    cdb(0, 1, 32'h55, 1'b1, 32'h2000);
    cdb(1, 2, 32'h66, 1'b0, 32'h0);
    tick(); clr();
    chk("t6_no_commit_yet", commit_valid, 2'b00);
    push_c(10, 32'h44, 1); push_c(11, 32'h55, 2);
    exp_flush_q.push_back(32'h2000);
    cdb(0, 0, 32'h44, 1'b0, 32'h0);
    cdb(1, 3, 32'h77, 1'b0, 32'h0);
    tick(); clr();
    chk("t6_dual_commit", commit_valid, 2'b11);
    alloc_valid = 1'b1; alloc_rd = 5'd14; alloc_type = 3'd7;
    tick();
    chk("t6_flush", flush, 1);
    chk("t6_flush_pc", flush_pc, 32'h2000);
    chk("t6_count", count, 0);
    chk("t6_head", rob_head, 2);
    chk("t6_tail", rob_tail, 2);
    chk("t6_alloc_ready", alloc_ready, 0);
    chk("t6_commit_valid", commit_valid, 2'b00);
    tick();
    chk("t6_flush_cycle_alloc_dropped", count, 0);
    chk("t6_flush_low", flush, 0);
    chk("t6_alloc_ready_back", alloc_ready, 1);
    tick();
    alloc_valid = 1'b0;
    chk("t6_resume_count", count, 1);
    chk("t6_resume_tail", rob_tail, 3);
    repeat (3) tick();
    chk("t6_no_stale_commit", commit_valid, 2'b00);

    chk("commit_queue_drained", exp_commit_q.size(), 0);
    chk("flush_queue_drained", exp_flush_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reorder_buffer_mc.md
# reorder_buffer_mc

Parametrised, multi-port reorder buffer for the Tomasulo core. It allocates entries in program order at dispatch and accepts results from `CDB_N` common-data-bus ports per cycle. It retires up to `COMMIT_N` completed instructions per cycle in order, and on a committed branch mispredict it raises a registered flush with the redirect PC. It sits between dispatch/reservation stations and the architectural register file, and it owns the head and tail pointers, so dispatch no longer supplies the tail.

## Interface
Parameters:
- `DEPTH`, 32, number of entries; must be a power of two, ≥4. `TAG_W` = $clog2(DEPTH).
- `XLEN`, 32, data/PC width.
- `CDB_N`, 2, number of CDB write ports.
- `COMMIT_N`, 2, maximum retirements per cycle; 1 ≤ `COMMIT_N` ≤ `DEPTH`.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alloc_valid`  in  1  dispatch requests an entry.
- `alloc_ready`  out  1  high iff count < `DEPTH` and `flush` is low.
- `alloc_rd`  in  5  destination register.
- `alloc_pc`  in  XLEN  instruction PC.
- `alloc_type`  in  3  instruction class, stored and returned unchanged.
- `alloc_tag`  out  TAG_W  tag given to the allocating instruction (= `rob_tail`).
- `cdb_valid`  in  CDB_N  per-port result valid.
- `cdb_tag`  in  CDB_N*TAG_W  per-port ROB tag.
- `cdb_value`  in  CDB_N*XLEN  per-port result.
- `cdb_mispredict`  in  CDB_N  per-port: the branch resolved mispredicted.
- `cdb_target`  in  CDB_N*XLEN  per-port correct next PC.
- `commit_valid`  out  COMMIT_N  per-slot retire strobe. Slot 0 is the oldest.
- `commit_rd`  out  COMMIT_N*5  per-slot destination.
- `commit_value`  out  COMMIT_N*XLEN  per-slot result.
- `commit_type`  out  COMMIT_N*3  per-slot class.
- `flush`  out  1  one-cycle redirect pulse.
- `flush_pc`  out  XLEN  redirect target; valid while `flush` is high.
- `rob_head`, `rob_tail`  out  TAG_W  oldest and next-free index.
- `count`  out  TAG_W+1  occupied entries.
- `empty`, `full`  out  1  count==0 and count==`DEPTH`.

## Operation
- Each entry holds: `busy`, `done`, `misp`, `rd`, `pc`, `type`, `value`, `target`.
- **Allocate** (alloc_valid && alloc_ready):
  - write the entry at tail with busy=1, done=0, misp=0;
  - tail advances by 1 modulo `DEPTH`.
- **CDB writeback**: for each port p with cdb_valid[p] whose tagged entry is busy and not done:
  - set done=1 and write value, misp and target;
  - writes to non-busy or already-done entries are ignored;
  - if two ports carry the same tag in one cycle, the lower port index wins.
- **Commit**: slot i is valid iff entries head..head+i are all busy && done and no slot j<i holds misp=1.
  - Committed entries clear busy; head advances by the number of valid slots.
  - count(next) = count + alloc − commits.
- **Mispredict**: when a committing slot holds misp=1:
  - that entry still retires (its rd/value appear on its slot);
  - at that edge all entries clear busy, tail←new head, count←0;
  - flush←1 and flush_pc←that entry's target for exactly the next cycle.
  - Same-cycle allocation and CDB writes to surviving entries are discarded.
- **Full**: no allocation, even if a commit frees a slot in the same cycle (no bypass).
- **Pointers**: head and tail wrap naturally at TAG_W bits; count disambiguates full from empty.
- **rd=0** still commits with commit_valid=1; the register file ignores the write.

## Timing
- **Reset values** (asynchronous on rst_n low):
  - all busy/done/misp = 0; head = tail = count = 0;
  - empty=1, full=0, alloc_ready=1, flush=0, flush_pc=0;
  - commit_valid=0 with commit_rd/commit_value/commit_type = 0.
  - Reset mid-operation discards everything with no flush pulse.
- `alloc_tag`, `alloc_ready`, all commit_* outputs, `empty`, `full` and `count` are combinational from registered state.
- **CDB → commit**: a result captured at edge t can drive commit_valid no earlier than the cycle after t.
- **Allocate → commit**: minimum 2 cycles (allocate at edge t, CDB at edge t+1, commit in the cycle after t+1).
- `flush` is high only in the cycle after the mispredict commit edge. `alloc_ready`=0 during that cycle, and dispatch resumes the next cycle.

## Test plan
- **Reset**: hold rst_n=0 mid-run with 5 entries busy, then release → count=0, empty=1, head=tail=0, flush=0, commit_valid=0.
- **In-order dual commit**: allocate tags 0,1,2 (rd=1,2,3); CDB writes tag 2 then tags 0 and 1 in one cycle (values 0xA, 0xB, 0xC) → next cycle commit_valid=2'b11 with rd 1,2; the following cycle slot0 commits rd=3 value 0xC.
- **CDB conflict**: ports 0 and 1 both write tag 4 (values 0x11 and 0x22) → committed value 0x11.
- **Full and wrap**: allocate 32 → full=1, alloc_ready=0. Complete and commit 2, allocate 2 more → tails 0 and 1, count=32, wrap is correct.
- **Mispredict**: tags 0-3 allocated; tag 1 completes with misp=1, target=0x2000; tags 0, 2 and 3 complete → tags 0 and 1 commit together; next cycle flush=1, flush_pc=0x2000, count=0, tail=head=2; tags 2 and 3 never commit.
- **Mispredict during alloc**: alloc_valid=1 in the mispredict commit cycle → the allocation is dropped and count=0 after flush.
